mdu_pipe: RTL and testbench

//  Parametrised RV32M/RV64M multiply-divide unit for the core execute stage. The multiplier is

---
 rtl/mdu_pipe.sv | 188 ++++++++++++++++++
 tb/tb_mdu_pipe.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mdu_pipe.sv
// RV32M/RV64M multiply-divide unit: pipelined multiplier plus iterative restoring divider.
// Results and tags share one registered output port; the divider holds busy for its whole run.
module mdu_pipe #(
  parameter int P_DATA_MSB   = 31,
  parameter int P_MUL_STAGES = 2,
  parameter int P_DIV_RADIX  = 1,
  parameter int P_TAG_MSB    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_DATA_MSB:0]   i_mdu_rs1,
  input  logic [P_DATA_MSB:0]   i_mdu_rs2,
  input  logic [2:0]            i_mdu_op,
  input  logic [P_TAG_MSB:0]    i_mdu_tag,
  input  logic                  i_mdu_valid,
  output logic                  o_mdu_busy,
  output logic                  o_mdu_valid,
  output logic [P_DATA_MSB:0]   o_mdu_rd,
  output logic [P_TAG_MSB:0]    o_mdu_tag
);
  localparam int W  = P_DATA_MSB + 1;
  localparam int T  = P_TAG_MSB + 1;
  localparam int K  = P_DIV_RADIX;
  localparam int N  = W / K;
  localparam int CW = $clog2(N + 1);
  localparam int MS = (P_MUL_STAGES > 1) ? P_MUL_STAGES - 1 : 1;

  if (W != 32 && W != 64) begin : g_bad_w
    $error("mdu_pipe: P_DATA_MSB must give W of 32 or 64");
  end
  if (P_MUL_STAGES < 1 || P_MUL_STAGES > 4) begin : g_bad_s
    $error("mdu_pipe: P_MUL_STAGES must be 1..4");
  end
  if ((K != 1 && K != 2 && K != 4) || (W % K) != 0) begin : g_bad_k
    $error("mdu_pipe: P_DIV_RADIX must be 1, 2 or 4 and divide W");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic w_acc, w_macc, w_dacc;
  assign o_mdu_busy = (r_state != S_IDLE);
  assign w_acc  = i_mdu_valid & ~o_mdu_busy;
  assign w_macc = w_acc & ~i_mdu_op[2];
  assign w_dacc = w_acc &  i_mdu_op[2];

  // ---------------- multiplier ----------------
  // Operands widened to W+1 so one signed multiplier covers all four sign combinations;
  // only the low 2W product bits are ever needed.
  logic signed [W:0]     w_ma, w_mb;
  logic signed [2*W-1:0] w_prod;
  logic [W-1:0]          w_mres;
  assign w_ma   = {(i_mdu_op[1:0] == 2'b01 || i_mdu_op[1:0] == 2'b10) & i_mdu_rs1[W-1], i_mdu_rs1};
  assign w_mb   = {(i_mdu_op[1:0] == 2'b01) & i_mdu_rs2[W-1], i_mdu_rs2};
  assign w_prod = w_ma * w_mb;
  assign w_mres = (i_mdu_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];

  logic [MS-1:0]         r_vld_pipe;
  logic [MS-1:0][W-1:0]  r_mres;
  logic [MS-1:0][T-1:0]  r_mtag;
  logic                  w_mlast_v;
  logic [W-1:0]          w_mlast_r;
  logic [T-1:0]          w_mlast_t;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_mres     <= '0;
      r_mtag     <= '0;
    end else begin
      r_vld_pipe[0] <= w_macc;
      r_mres[0]     <= w_mres;
      r_mtag[0]     <= i_mdu_tag;
      for (int i = 1; i < MS; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_mres[i]     <= r_mres[i-1];
        r_mtag[i]     <= r_mtag[i-1];
      end
    end
  end

  // The output register is the last multiplier stage, so one stage feeds it directly.
  if (P_MUL_STAGES == 1) begin : g_m1
    assign w_mlast_v = w_macc;
    assign w_mlast_r = w_mres;
    assign w_mlast_t = i_mdu_tag;
  end else begin : g_mn
    assign w_mlast_v = r_vld_pipe[MS-1];
    assign w_mlast_r = r_mres[MS-1];
    assign w_mlast_t = r_mtag[MS-1];
  end

  // ---------------- divider ----------------
  logic [W-1:0]     r_drem, r_dq, r_drs1;
  logic [2*W-2:0]   r_ddiv;
  logic [CW-1:0]    r_dcnt;
  logic [T-1:0]     r_dtag;
  logic             r_dnegq, r_dnegr, r_disrem, r_dz, r_dovf;

  logic             w_sgn;
  logic [W-1:0]     w_abs1, w_abs2;
  assign w_sgn  = ~i_mdu_op[0];
  assign w_abs1 = (w_sgn & i_mdu_rs1[W-1]) ? -i_mdu_rs1 : i_mdu_rs1;
  assign w_abs2 = (w_sgn & i_mdu_rs2[W-1]) ? -i_mdu_rs2 : i_mdu_rs2;

  logic [2*W-2:0] w_srem, w_sdiv;
  logic [W-1:0]   w_sq;
  always_comb begin
    w_srem = {{(W-1){1'b0}}, r_drem};
    w_sdiv = r_ddiv;
    w_sq   = r_dq;
    for (int k = 0; k < K; k++) begin
      if (w_srem >= w_sdiv) begin
        w_srem = w_srem - w_sdiv;
        w_sq   = {w_sq[W-2:0], 1'b1};
      end else begin
        w_sq   = {w_sq[W-2:0], 1'b0};
      end
      w_sdiv = w_sdiv >> 1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_dacc) w_state_nxt = S_RUN;
      S_RUN:   if (r_dcnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drem <= '0; r_dq <= '0; r_drs1 <= '0; r_ddiv <= '0; r_dcnt <= '0; r_dtag <= '0;
      r_dnegq <= 1'b0; r_dnegr <= 1'b0; r_disrem <= 1'b0; r_dz <= 1'b0; r_dovf <= 1'b0;
    end else if (w_dacc) begin
      r_drem   <= w_abs1;
      r_ddiv   <= {w_abs2, {(W-1){1'b0}}};
      r_dq     <= '0;
      r_dcnt   <= CW'(N);
      r_drs1   <= i_mdu_rs1;
      r_dtag   <= i_mdu_tag;
      r_disrem <= i_mdu_op[1];
      r_dnegq  <= w_sgn & (i_mdu_rs1[W-1] ^ i_mdu_rs2[W-1]);
      r_dnegr  <= w_sgn & i_mdu_rs1[W-1];
      r_dz     <= (i_mdu_rs2 == '0);
      r_dovf   <= w_sgn & (i_mdu_rs1 == {1'b1, {(W-1){1'b0}}}) & (i_mdu_rs2 == '1);
    end else if (r_state == S_RUN) begin
      r_drem <= w_srem[W-1:0];
      r_ddiv <= w_sdiv;
      r_dq   <= w_sq;
      r_dcnt <= r_dcnt - CW'(1);
    end
  end

  logic [W-1:0] w_dres;
  always_comb begin
    if (r_dz)        w_dres = r_disrem ? r_drs1 : '1;
    else if (r_dovf) w_dres = r_disrem ? '0 : {1'b1, {(W-1){1'b0}}};
    else if (r_disrem) w_dres = r_dnegr ? -r_drem : r_drem;
    else             w_dres = r_dnegq ? -r_dq : r_dq;
  end

  // Busy blocks issue during a divide, so the two sources never strobe together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mdu_valid <= 1'b0;
      o_mdu_rd    <= '0;
      o_mdu_tag   <= '0;
    end else if (r_state == S_DONE) begin
      o_mdu_valid <= 1'b1;
      o_mdu_rd    <= w_dres;
      o_mdu_tag   <= r_dtag;
    end else if (w_mlast_v) begin
      o_mdu_valid <= 1'b1;
      o_mdu_rd    <= w_mlast_r;
      o_mdu_tag   <= w_mlast_t;
    end else begin
      o_mdu_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mdu_pipe.sv
// Directed bench for mdu_pipe (W=32, 2 mul stages, radix-2 divider: div latency 18).
module tb_mdu_pipe;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
                         OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [2:0]  op  = '0;
  logic [4:0]  tag = '0;
  logic        vin = 1'b0;
  logic        busy, vout;
  logic [31:0] rd;
  logic [4:0]  tout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_pipe #(.P_DATA_MSB(31), .P_MUL_STAGES(2), .P_DIV_RADIX(2), .P_TAG_MSB(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_mdu_rs1(rs1), .i_mdu_rs2(rs2), .i_mdu_op(op),
    .i_mdu_tag(tag), .i_mdu_valid(vin), .o_mdu_busy(busy), .o_mdu_valid(vout),
    .o_mdu_rd(rd), .o_mdu_tag(tout)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    op = o; rs1 = a; rs2 = b; tag = t; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  // Called #1 after the accept edge (or later, with lat0 edges already counted).
  task automatic wait_res(input string name, input logic [31:0] erd, input logic [4:0] etag,
                          input int elat, input int lat0);
    int lat;
    lat = lat0;
    while (!vout && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".valid"}, 64'(vout), 64'd1);
    chk({name, ".rd"},    64'(rd),   64'(erd));
    chk({name, ".tag"},   64'(tout), 64'(etag));
    chk({name, ".lat"},   64'(lat),  64'(elat));
  endtask

  initial begin
    int strobes;
    #12;
    chk("rst.valid", 64'(vout), 64'd0);
    chk("rst.rd",    64'(rd),   64'd0);
    chk("rst.tag",   64'(tout), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1-2: multiplies
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
    wait_res("mul", 32'hFFFF_FFEB, 5'd3, 2, 1);
    @(posedge clk); #1;
    chk("mul.strobe_once", 64'(vout), 64'd0);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4);
    wait_res("mulh", 32'h4000_0000, 5'd4, 2, 1);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    wait_res("mulhsu", 32'hFFFF_FFFF, 5'd5, 2, 1);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    wait_res("mulhu", 32'hFFFF_FFFE, 5'd6, 2, 1);

    // 3: signed divides including overflow
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    wait_res("div_ovf", 32'h8000_0000, 5'd7, 18, 1);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    wait_res("rem_ovf", 32'h0, 5'd8, 18, 1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    wait_res("div_m7_2", 32'hFFFF_FFFD, 5'd9, 18, 1);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
    wait_res("rem_m7_2", 32'hFFFF_FFFF, 5'd10, 18, 1);

    // 4: divide by zero
    issue(OP_DIVU, 32'd9, 32'd0, 5'd11);
    chk("divu0.busy", 64'(busy), 64'd1);
    wait_res("divu0", 32'hFFFF_FFFF, 5'd11, 18, 1);
    issue(OP_REMU, 32'd5, 32'd0, 5'd12);
    wait_res("remu0", 32'd5, 5'd12, 18, 1);

    // 5: four back-to-back muls then a div behind them
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        op = OP_MUL; rs1 = 32'(i + 2); rs2 = 32'h10; tag = 5'(i);
      end else begin
        op = OP_DIV; rs1 = 32'd100; rs2 = 32'hFFFF_FFFD; tag = 5'd20;
      end
      vin = 1'b1;
      @(posedge clk); #1;
      if (i > 0) begin
        chk($sformatf("b2b%0d.valid", i - 1), 64'(vout), 64'd1);
        chk($sformatf("b2b%0d.tag", i - 1),   64'(tout), 64'(i - 1));
        chk($sformatf("b2b%0d.rd", i - 1),    64'(rd),   64'((i + 1) * 16));
      end
    end
    op = OP_MUL; rs1 = 32'h12345; rs2 = 32'h100; tag = 5'd21;
    chk("b2b.busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    wait_res("b2b_div", 32'hFFFF_FFDF, 5'd20, 18, 2);
    chk("b2b.busy_strobe", 64'(busy), 64'd0);
    @(posedge clk); #1;
    vin = 1'b0;
    chk("held.gap", 64'(vout), 64'd0);
    @(posedge clk); #1;
    chk("held.valid", 64'(vout), 64'd1);
    chk("held.rd",    64'(rd),   64'h0123_4500);
    chk("held.tag",   64'(tout), 64'd21);

    // 6: asynchronous reset mid-divide
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 64'(vout), 64'd0);
    chk("arst.rd",    64'(rd),   64'd0);
    chk("arst.tag",   64'(tout), 64'd0);
    chk("arst.busy",  64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    strobes = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (vout) strobes++;
    end
    chk("arst.no_stale", 64'(strobes), 64'd0);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd2);
    wait_res("post_rst_divu", 32'd14, 5'd2, 18, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
